// File: rtl/ssub_pkg.sv
// Shared types and constants for the signed-subtractor result path.
package ssub_pkg;

  localparam int unsigned SSUB_WIDTH = 32;

  localparam logic [1:0] SEL_IN1 = 2'b00;
  localparam logic [1:0] SEL_IN2 = 2'b01;
  localparam logic [1:0] SEL_IN3 = 2'b10;
  localparam logic [1:0] SEL_IN4 = 2'b11;

  // Per-entry sideband stored next to the (width-parameterised) result data
  typedef struct packed {
    logic [1:0] sel;
    logic       zero;
    logic       neg;
    logic       dis;
  } ssub_meta_t;

endpackage

// File: rtl/ssub_flag_gen.sv
// Gates the selector output by orf and derives the zero/negative/disabled flags.
module ssub_flag_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic             orf,
  output logic [WIDTH-1:0] gated,
  output logic             zero,
  output logic             neg,
  output logic             dis
);

  always_comb begin
    gated = orf ? data : '0;
    zero  = (gated == '0);
    neg   = orf & data[WIDTH-1];
    dis   = ~orf;
  end

endmodule

// File: rtl/ssub_result_buffer.sv
// Registered FIFO stage after the 4:1 result selector: stores gated result plus
// select code and flags, valid/ready on both sides, saturating drop counter.
module ssub_result_buffer
  import ssub_pkg::*;
#(
  parameter int unsigned WIDTH = SSUB_WIDTH,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_orf,
  input  logic [1:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_dis,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  ssub_meta_t       meta_q [DEPTH];
  ssub_meta_t       meta_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             live_q, live_d;

  logic [WIDTH-1:0] gated;
  logic             f_zero, f_neg, f_dis;
  logic             push, pop;

  ssub_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .data  (in_data),
    .orf   (in_orf),
    .gated (gated),
    .zero  (f_zero),
    .neg   (f_neg),
    .dis   (f_dis)
  );

  // live_q holds in_ready low until the first edge after reset release
  assign in_ready  = live_q && (level_q < FULL_LVL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data = data_q[rd_ptr_q];
  assign out_sel  = meta_q[rd_ptr_q].sel;
  assign out_zero = meta_q[rd_ptr_q].zero;
  assign out_neg  = meta_q[rd_ptr_q].neg;
  assign out_dis  = meta_q[rd_ptr_q].dis;
  assign level    = level_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    data_d     = data_q;
    meta_d     = meta_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    live_d     = 1'b1;

    if (push) begin
      data_d[wr_ptr_q] = gated;
      meta_d[wr_ptr_q] = '{sel: in_sel, zero: f_zero, neg: f_neg, dis: f_dis};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (in_valid && !in_ready && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        meta_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      live_q     <= 1'b0;
    end else begin
      data_q     <= data_d;
      meta_q     <= meta_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      live_q     <= live_d;
    end
  end

endmodule

// File: tb/tb_ssub_result_buffer.sv
// Directed self-checking bench for ssub_result_buffer (DEPTH=2, CNT_W=2).
module tb_ssub_result_buffer;
  import ssub_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_orf;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic        out_dis;
  logic [1:0]  level;
  logic [1:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  ssub_result_buffer #(.WIDTH(32), .DEPTH(2), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_orf    (in_orf),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_dis   (out_dis),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic push_vec(input logic [31:0] d, input logic orf, input logic [1:0] sel);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_orf   = orf;
    in_sel   = sel;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_orf = 1'b0; in_sel = '0;
    #3;
    checks++;
    if ({out_valid, in_ready, level, drop_cnt} !== 6'b0 ||
        {out_data, out_sel, out_zero, out_neg, out_dis} !== 37'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b rdy=%b lvl=%0d drop=%0d data=%h sel=%b z=%b n=%b d=%b, want all 0",
               out_valid, in_ready, level, drop_cnt, out_data, out_sel, out_zero, out_neg, out_dis);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFE; in_orf = 1'b1; in_sel = SEL_IN3;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, out_sel, out_zero, out_neg, out_dis} !== {1'b1, 32'hFFFF_FFFE, 2'b10, 3'b010}) begin
      errors++;
      $display("FAIL single_head: v=%b data=%h sel=%b z=%b n=%b d=%b want 1 fffffffe 10 0 1 0",
               out_valid, out_data, out_sel, out_zero, out_neg, out_dis);
    end
    checks++;
    if (level !== 2'd1) begin
      errors++; $display("FAIL single_level: got %0d want 1", level);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 2'd0) begin
      errors++; $display("FAIL single_pop: v=%b lvl=%0d want 0 0", out_valid, level);
    end
  endtask

  task automatic test_disabled();
    out_ready = 1'b0;
    push_vec(32'h1234_5678, 1'b0, SEL_IN2);
    checks++;
    if ({out_valid, out_data, out_sel, out_zero, out_neg, out_dis} !== {1'b1, 32'h0, 2'b01, 3'b101}) begin
      errors++;
      $display("FAIL disabled_head: v=%b data=%h sel=%b z=%b n=%b d=%b want 1 00000000 01 1 0 1",
               out_valid, out_data, out_sel, out_zero, out_neg, out_dis);
    end
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    checks++;
    if (level !== 2'd0) begin
      errors++; $display("FAIL disabled_pop: lvl=%0d want 0", level);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    out_ready = 1'b0;
    push_vec(32'd1, 1'b1, SEL_IN1);
    checks++;
    if (level !== 2'd1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ovf_first: lvl=%0d rdy=%b want 1 1", level, in_ready);
    end
    push_vec(32'd2, 1'b1, SEL_IN1);
    checks++;
    if (level !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_full: lvl=%0d rdy=%b want 2 0", level, in_ready);
    end
    push_vec(32'd3, 1'b1, SEL_IN1);
    checks++;
    if (level !== 2'd2 || drop_cnt !== 2'd1) begin
      errors++; $display("FAIL ovf_drop: lvl=%0d drop=%0d want 2 1", level, drop_cnt);
    end
    @(negedge clk);
    out_ready = 1'b1;
    checks++;
    if (out_data !== 32'd1 || out_zero !== 1'b0) begin
      errors++; $display("FAIL ovf_pop1: data=%h z=%b want 00000001 0", out_data, out_zero);
    end
    tick();
    checks++;
    if (out_data !== 32'd2 || level !== 2'd1) begin
      errors++; $display("FAIL ovf_pop2: data=%h lvl=%0d want 00000002 1", out_data, level);
    end
    tick();
    checks++;
    if (level !== 2'd0 || out_valid !== 1'b0 || drop_cnt !== 2'd1) begin
      errors++; $display("FAIL ovf_empty: lvl=%0d v=%b drop=%0d want 0 0 1", level, out_valid, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    out_ready = 1'b0;
    push_vec(32'h0000_000A, 1'b1, SEL_IN1);
    push_vec(32'h0000_000B, 1'b1, SEL_IN2);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h8000_000C; in_orf = 1'b1; in_sel = SEL_IN4;
    out_ready = 1'b1;
    tick();
    checks++;
    if (level !== 2'd1 || drop_cnt !== 2'd1 || out_data !== 32'h0000_000B || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fpp_simul: lvl=%0d drop=%0d data=%h rdy=%b want 1 1 0000000b 1",
               level, drop_cnt, out_data, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (level !== 2'd2 || out_data !== 32'h0000_000B || out_sel !== 2'b01) begin
      errors++; $display("FAIL fpp_pushc: lvl=%0d data=%h sel=%b want 2 0000000b 01", level, out_data, out_sel);
    end
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_data, out_sel, out_neg, out_zero, level} !== {32'h8000_000C, 2'b11, 1'b1, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL fpp_order: data=%h sel=%b n=%b z=%b lvl=%0d want 8000000c 11 1 0 1",
               out_data, out_sel, out_neg, out_zero, level);
    end
    tick();
    checks++;
    if (level !== 2'd0) begin
      errors++; $display("FAIL fpp_empty: lvl=%0d want 0", level);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_drop;
    apply_reset();
    out_ready = 1'b0;
    push_vec(32'h11, 1'b1, SEL_IN1);
    push_vec(32'h22, 1'b1, SEL_IN1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h33;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_drop = (i >= 3) ? 2'd3 : 2'(i);
      checks++;
      if (drop_cnt !== exp_drop) begin
        errors++; $display("FAIL sat_cycle%0d: drop=%0d want %0d", i, drop_cnt, exp_drop);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 2'd2 || out_data !== 32'h11) begin
      errors++; $display("FAIL sat_hold: lvl=%0d data=%h want 2 00000011", level, out_data);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    push_vec(32'h55, 1'b1, SEL_IN1);
    push_vec(32'h66, 1'b1, SEL_IN1);
    push_vec(32'h77, 1'b1, SEL_IN1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, level, drop_cnt, in_ready} !== 6'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: v=%b lvl=%0d drop=%0d rdy=%b data=%h want all 0",
               out_valid, level, drop_cnt, in_ready, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ready_pre: rdy=%b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || level !== 2'd0) begin
      errors++; $display("FAIL mid_ready_post: rdy=%b lvl=%0d want 1 0", in_ready, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_disabled();
    test_overflow();
    test_full_push_pop();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssub_result_buffer.md
Name: ssub_result_buffer

Overview:
- Registered output stage sitting directly downstream of the signed-subtractor 4:1 result selector.
- Captures the selected 32-bit result together with its select code, derives N/Z flags, and holds results in a small FIFO.
- Uses a valid/ready handshake to decouple the combinational ALU from the register-file writeback.
- Turns the selector's unclocked output into a clean, back-pressurable stream.

Parameters:
- WIDTH, 32, datapath width of the result.
- DEPTH, 2, number of FIFO entries; must be a power of two and at least 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream result present this cycle
- in_ready  output  1  buffer can accept an entry
- in_data  input  WIDTH  selected result from the 4:1 selector
- in_orf  input  1  selector enable; when 0 the selector output is forced to zero
- in_sel  input  2  {dr, control} select code used for in_data
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_data  output  WIDTH  head result
- out_sel  output  2  head select code
- out_zero  output  1  head result == 0
- out_neg  output  1  head result MSB
- out_dis  output  1  head was captured with in_orf=0
- level  output  log2(DEPTH)+1  current occupancy
- drop_cnt  output  CNT_W  count of in_valid cycles rejected because the buffer was full; saturates

Behaviour:
- Reset: asynchronous, active-high, reset is decided for this block. While rst is high:
  - level=0, out_valid=0, in_ready=0, drop_cnt=0.
  - out_data, out_sel, out_zero, out_neg and out_dis all read 0.
  - Pointers are cleared.
- After reset: in_ready goes high on the first clk edge after rst deasserts.
- Accept: push when in_valid && in_ready.
- Pop: when out_valid && out_ready.
- in_ready: equals (level < DEPTH), registered-free, derived from level. It is not combinationally dependent on out_ready, so there is no pop-through-full.
- Flags:
  - Computed at push time and stored with the entry.
  - zero = (in_orf ? in_data : 0) == 0.
  - neg = in_orf & in_data[WIDTH-1].
  - Stored data is (in_orf ? in_data : 0).
  - dis = ~in_orf.
- Latency: an entry pushed at edge N is visible on out_* after edge N when the FIFO was empty, i.e. one cycle of latency. There is no combinational bypass.
- Outputs:
  - out_* are driven directly from the head entry registers.
  - When empty, out_valid=0 and out_data/flags hold the last-popped values (don't-care for verification except after reset).
- Simultaneous push and pop:
  - When full: the pop is done, the push is not accepted (in_ready=0), and level drops to DEPTH-1.
  - When not full and not empty: level is unchanged.
  - When empty: the push is allowed and the pop is impossible.
- Drop counting: a cycle with in_valid=1 and in_ready=0 (not in reset) increments drop_cnt, saturating at 2^CNT_W-1.
- Pointers: read/write pointers wrap modulo DEPTH. level is tracked explicitly, with full = (level==DEPTH).
- in_sel: stored verbatim. No check of orf/sel consistency.
- Reset mid-operation: all entries are discarded immediately and asynchronously. No partial handshake completes.
- X-safety: with in_valid=0, in_data/in_sel/in_orf are ignored.

Decomposition:
- Shared package ssub_pkg:
  - SEL_IN1=2'b00, SEL_IN2=2'b01, SEL_IN3=2'b10, SEL_IN4=2'b11.
  - WIDTH default 32.
  - Entry record: data, sel, zero, neg, dis.
- Sub-module ssub_flag_gen (combinational): takes data and orf, produces gated data, zero, neg and dis. It is reused later by the adder-side buffer.
- FIFO storage and control stay in ssub_result_buffer.

Test Plan:
- Reset mid-stream: push 2 entries, assert rst asynchronously between edges -> out_valid, level and drop_cnt drop to 0 immediately; in_ready=1 one edge after release.
- Single push/pop: in_data=32'hFFFF_FFFE, in_orf=1, in_sel=2'b10, out_ready=1 -> next cycle out_valid=1, out_data=FFFF_FFFE, out_neg=1, out_zero=0, out_sel=10, out_dis=0; popped the same edge.
- Disabled capture: in_data=32'h1234_5678, in_orf=0, in_sel=2'b01 -> out_data=0, out_zero=1, out_neg=0, out_dis=1, out_sel=01.
- Fill and overflow: out_ready=0, push 3 back-to-back values 1,2,3 -> level=2, in_ready=0 after the 2nd push, value 3 rejected, drop_cnt=1. Then out_ready=1 -> pops return 1 then 2, in order.
- Full with simultaneous push/pop: FIFO full (A,B), in_valid=1 (C), out_ready=1 -> A popped, C not accepted, level=1, drop_cnt increments. Next cycle push C accepted -> order B, C.
- Saturation: CNT_W=2, hold in_valid=1 while full for 6 cycles -> drop_cnt=3 and stays at 3.
